// File: rtl/udp_transfer_sched.sv
// udp_transfer_sched: decodes UDP command packets into frame-aligned
// start/stop/burst control of the video packetizer, acknowledging every
// command through a request/done handshake toward the UDP transmitter.
module udp_transfer_sched #(
  parameter logic [7:0] MAGIC     = 8'hA5,
  parameter logic [7:0] ACK_MAGIC = 8'h5A,
  parameter logic [7:0] START     = "1",
  parameter logic [7:0] STOP      = "0"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_rec_pkt_done,
  input  logic        udp_rec_en,
  input  logic [31:0] udp_rec_data,
  input  logic [15:0] udp_rec_byte_num,
  input  logic        frame_start,
  input  logic        ack_done,
  output logic        transfer_flag,
  output logic        ack_req,
  output logic [31:0] ack_data,
  output logic [15:0] frames_left,
  output logic [1:0]  sched_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_START,
    C_STOP,
    C_FRAMES,
    C_QUERY,
    C_ERR
  } cmd_t;

  logic        cap_valid;
  logic [31:0] cap_word;
  logic [31:0] pkt_word;

  cmd_t        dec_cmd;
  logic [7:0]  dec_code;
  logic [15:0] dec_n;

  logic        pend_valid;
  cmd_t        pend_cmd;
  logic [7:0]  pend_code;
  logic [15:0] pend_n;

  state_t      state;
  state_t      state_nxt;
  logic        cnt;
  logic        cnt_nxt;
  logic [15:0] left_nxt;
  logic        apply;
  logic [7:0]  ack_status;
  logic [31:0] ack_word;

  // Only the first word of a packet carries the command; later words are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_word  <= '0;
    end else if (udp_rec_pkt_done) begin
      cap_valid <= 1'b0;
    end else if (udp_rec_en && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_word  <= udp_rec_data;
    end
  end

  // A packet that ends before any word was captured uses the word on the bus at done.
  assign pkt_word = cap_valid ? cap_word : udp_rec_data;

  // Translate the packet word and length into a command, ack opcode and frame count.
  always_comb begin
    dec_cmd  = C_ERR;
    dec_code = 8'hFF;
    dec_n    = pkt_word[15:0];
    if (udp_rec_byte_num == 16'd1) begin
      if (pkt_word[31:24] == START) begin
        dec_cmd  = C_START;
        dec_code = 8'h01;
      end else if (pkt_word[31:24] == STOP) begin
        dec_cmd  = C_STOP;
        dec_code = 8'h02;
      end
    end else if (udp_rec_byte_num == 16'd4 && pkt_word[31:24] == MAGIC) begin
      case (pkt_word[23:16])
        8'h01: begin
          dec_cmd  = C_START;
          dec_code = 8'h01;
        end
        8'h02: begin
          dec_cmd  = C_STOP;
          dec_code = 8'h02;
        end
        8'h03: begin
          dec_cmd  = (dec_n == 16'd0) ? C_STOP : C_FRAMES;
          dec_code = 8'h03;
        end
        8'h04: begin
          dec_cmd  = C_QUERY;
          dec_code = 8'h04;
        end
        default: begin
          dec_cmd  = C_ERR;
          dec_code = 8'hFF;
        end
      endcase
    end
  end

  // Frame events win over commands, so a command waits while frame_start is high.
  assign apply = pend_valid && !frame_start;

  // One-entry pending command; a newer packet replaces one not yet applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_cmd   <= C_ERR;
      pend_code  <= '0;
      pend_n     <= '0;
    end else if (udp_rec_pkt_done) begin
      pend_valid <= 1'b1;
      pend_cmd   <= dec_cmd;
      pend_code  <= dec_code;
      pend_n     <= dec_n;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end
  end

  // Next scheduler state, mode and frame count from frame events or the pending command.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    left_nxt  = frames_left;
    if (frame_start) begin
      case (state)
        S_ARM: state_nxt = S_RUN;
        S_RUN: begin
          if (cnt && frames_left == 16'd1) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 1'b0;
            left_nxt  = '0;
          end else if (cnt) begin
            left_nxt = frames_left - 16'd1;
          end
        end
        S_DRAIN: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 1'b0;
          left_nxt  = '0;
        end
        default: state_nxt = state;
      endcase
    end else if (pend_valid) begin
      case (pend_cmd)
        C_START: begin
          cnt_nxt  = 1'b0;
          left_nxt = '0;
          if (state == S_IDLE) state_nxt = S_ARM;
          else if (state == S_DRAIN) state_nxt = S_RUN;
        end
        C_FRAMES: begin
          cnt_nxt  = 1'b1;
          left_nxt = pend_n;
          if (state == S_IDLE) state_nxt = S_ARM;
          else if (state == S_DRAIN) state_nxt = S_RUN;
        end
        C_STOP: begin
          if (state == S_ARM) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 1'b0;
            left_nxt  = '0;
          end else if (state == S_RUN) begin
            state_nxt = S_DRAIN;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  assign ack_status = (pend_cmd == C_ERR) ? 8'hEE : 8'h00;
  assign ack_word   = {ACK_MAGIC, pend_code, ack_status, 6'b0, state_nxt};

  // State register plus registered flag and acknowledge outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 1'b0;
      frames_left   <= '0;
      transfer_flag <= 1'b0;
      ack_req       <= 1'b0;
      ack_data      <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      frames_left   <= left_nxt;
      transfer_flag <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      if (apply) begin
        ack_req  <= 1'b1;
        ack_data <= ack_word;
      end else if (ack_done) begin
        ack_req <= 1'b0;
      end
    end
  end

  assign sched_state = state;

endmodule
